lab2_proc_mem_responder_unit: RTL and testbench

//  Single-port memory responder: the memory-side end of the mem_req_4B_t /
//  mem_resp_4B_t val/rdy interface that the processor drives. It accepts one

---
 rtl/lab2_proc_mem_responder_unit.sv | 183 ++++++++++++++++++
 tb/tb_lab2_proc_mem_responder_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_mem_responder_unit.sv
// Single-port word-array memory responder with fixed-latency, in-order val/rdy responses.
// Optional LAB2_MEM_RESP_ADDR_CHECK_EN flags out-of-range addresses instead of wrapping.
module lab2_proc_mem_responder_unit #(
  parameter int p_nwords     = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] req_msg,
  input  logic        req_val,
  output logic        req_rdy,
  output logic [46:0] resp_msg,
  output logic        resp_val,
  input  logic        resp_rdy
);

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

  localparam int IW = $clog2(p_nwords);
  localparam int CW = $clog2(p_resp_depth + 1);
  localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;

  mem_req_t        req;
  logic [31:0]     mem_q [p_nwords];
  logic            acc;
  logic            fire;
  logic [CW-1:0]   cred_q, cred_d;
  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic [2:0]      nb;
  logic [3:0]      lo, hi;
  logic [3:0]      lane;
  logic [31:0]     rshift, rmask, wdata;
  logic            is_wr, oob, wen;
  mem_resp_t       in_m;
  logic            enq_v;
  mem_resp_t       enq_m;

  assign req     = mem_req_t'(req_msg);
  assign req_rdy = reset && (cred_q < CW'(p_resp_depth));
  assign acc     = req_val && req_rdy;
  assign fire    = resp_val && resp_rdy;

`ifdef LAB2_MEM_RESP_ADDR_CHECK_EN
  assign oob = (req.addr >= 32'(4 * p_nwords));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req.addr[31:IW+2];
  assign oob = 1'b0;
`endif

  always_comb begin
    idx    = req.addr[IW+1:2];
    off    = req.addr[1:0];
    nb     = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};
    lo     = {2'b00, off};
    hi     = lo + {1'b0, nb};
    lane   = '0;
    rmask  = '0;
    for (int i = 0; i < 4; i++) begin
      lane[i] = (4'(i) >= lo) && (4'(i) < hi);
      rmask[8*i +: 8] = (3'(i) < nb) ? 8'hFF : 8'h00;
    end
    rshift = mem_q[idx] >> {off, 3'b000};
    wdata  = req.data << {off, 3'b000};
    is_wr  = (req.type_ == 3'd1) || (req.type_ == 3'd2);
    wen    = acc && is_wr && !oob;
    in_m        = '0;
    in_m.type_  = req.type_;
    in_m.opaque = req.opaque;
    in_m.len    = req.len;
    in_m.test   = oob ? 2'b01 : 2'b00;
    in_m.data   = (is_wr || oob) ? 32'h0 : (rshift & rmask);
  end

  // Array is not reset; reads above see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < 4; i++) begin
        if (lane[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    cred_d = cred_q;
    unique case ({acc, fire})
      2'b10:   cred_d = cred_q + CW'(1);
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cred_q <= '0;
    else        cred_q <= cred_d;
  end

  generate
    if (p_latency == 1) begin : g_nopipe
      assign enq_v = acc;
      assign enq_m = in_m;
    end else begin : g_pipe
      logic      pv_q [p_latency-1];
      logic      pv_d [p_latency-1];
      mem_resp_t pm_q [p_latency-1];
      mem_resp_t pm_d [p_latency-1];
      always_comb begin
        pv_d[0] = acc;
        pm_d[0] = in_m;
        for (int i = 1; i < p_latency - 1; i++) begin
          pv_d[i] = pv_q[i-1];
          pm_d[i] = pm_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < p_latency - 1; i++) begin
            pv_q[i] <= 1'b0;
            pm_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < p_latency - 1; i++) begin
            pv_q[i] <= pv_d[i];
            pm_q[i] <= pm_d[i];
          end
        end
      end
      assign enq_v = pv_q[p_latency-2];
      assign enq_m = pm_q[p_latency-2];
    end
  endgenerate

  mem_resp_t     fifo_q [p_resp_depth];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_resp_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wptr_d = enq_v ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = fire  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(enq_v) - CW'(fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Credits bound occupancy, so enqueue never overwrites a live entry.
  always_ff @(posedge clk) begin
    if (enq_v) fifo_q[wptr_q] <= enq_m;
  end

  assign resp_val = (cnt_q != '0);
  assign resp_msg = resp_val ? 47'(fifo_q[rptr_q]) : '0;

endmodule

// File: tb/tb_lab2_proc_mem_responder_unit.sv
// Directed bench for lab2_proc_mem_responder_unit (default parameters).
// Inputs change at negedge+1; outputs are sampled there too.
module tb_lab2_proc_mem_responder_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [76:0] req_msg;
  logic        req_val;
  logic        req_rdy;
  logic [46:0] resp_msg;
  logic        resp_val;
  logic        resp_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  lab2_proc_mem_responder_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req_msg  (req_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] rq(input logic [2:0] t, input logic [7:0] o,
                                     input logic [31:0] a, input logic [1:0] l,
                                     input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [46:0] rs(input logic [2:0] t, input logic [7:0] o,
                                     input logic [1:0] ts, input logic [1:0] l,
                                     input logic [31:0] d);
    return {t, o, ts, l, d};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [76:0] m);
    req_msg = m;
    req_val = 1'b1;
    for (int k = 0; k < 20 && !req_rdy; k++) step();
    chk("issue_rdy", 64'(req_rdy), 64'd1);
    step();
    req_val = 1'b0;
  endtask

  task automatic get(input string tag, input logic [46:0] exp);
    for (int k = 0; k < 20 && !resp_val; k++) step();
    chk(tag, 64'(resp_msg), 64'(exp));
    step();
  endtask

  task automatic txn(input string tag, input logic [76:0] m,
                     input logic [46:0] exp);
    issue(m);
    get(tag, exp);
  endtask

  int idx, got, first, last, both, seen;
  logic a, f;

  initial begin
    req_msg  = '0;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    #2 reset = 1'b0;
    step();
    step();
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_resp_msg", 64'(resp_msg), 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_rdy", 64'(req_rdy), 64'd1);

    // write then read, cycle-exact latency
    req_msg = rq(3'd1, 8'd3, 32'h10, 2'd0, 32'hdeadbeef);
    req_val = 1'b1;
    step();
    chk("t1_no_early", 64'(resp_val), 64'd0);
    req_msg = rq(3'd0, 8'd4, 32'h10, 2'd0, 32'h0);
    step();
    req_val = 1'b0;
    chk("t1_wr_val", 64'(resp_val), 64'd1);
    chk("t1_wr_msg", 64'(resp_msg), 64'(rs(3'd1, 8'd3, 2'd0, 2'd0, 32'h0)));
    step();
    chk("t1_rd_val", 64'(resp_val), 64'd1);
    chk("t1_rd_msg", 64'(resp_msg),
        64'(rs(3'd0, 8'd4, 2'd0, 2'd0, 32'hdeadbeef)));
    step();
    chk("t1_idle", 64'(resp_val), 64'd0);

    // byte lanes, AMO-as-read
    txn("t3_winit", rq(3'd2, 8'd5, 32'h20, 2'd0, 32'h11223344),
        rs(3'd2, 8'd5, 2'd0, 2'd0, 32'h0));
    txn("t3_rd21", rq(3'd0, 8'd6, 32'h21, 2'd2, 32'h0),
        rs(3'd0, 8'd6, 2'd0, 2'd2, 32'h00002233));
    txn("t3_wr22", rq(3'd1, 8'd7, 32'h22, 2'd1, 32'hffffffaa),
        rs(3'd1, 8'd7, 2'd0, 2'd1, 32'h0));
    txn("t3_rd20", rq(3'd0, 8'd8, 32'h20, 2'd0, 32'h0),
        rs(3'd0, 8'd8, 2'd0, 2'd0, 32'h11aa3344));
    txn("t3_rd23", rq(3'd0, 8'd9, 32'h23, 2'd2, 32'h0),
        rs(3'd0, 8'd9, 2'd0, 2'd2, 32'h00000011));
    txn("t3_amo", rq(3'd3, 8'd10, 32'h20, 2'd0, 32'hffffffff),
        rs(3'd3, 8'd10, 2'd0, 2'd0, 32'h11aa3344));
    txn("t3_amo_nowr", rq(3'd0, 8'd11, 32'h20, 2'd0, 32'h0),
        rs(3'd0, 8'd11, 2'd0, 2'd0, 32'h11aa3344));

    // credit back-pressure, then sustained stream
    idx = 0; got = 0; first = -1; last = -1; both = 0;
    for (int cyc = 0; cyc < 60 && !(idx == 10 && got == 10); cyc++) begin
      resp_rdy = (cyc >= 8);
      req_val  = (idx < 10);
      req_msg  = rq(3'd0, 8'(8'h40 + idx), 32'h10, 2'd0, 32'h0);
      a = req_val && req_rdy;
      f = resp_val && resp_rdy;
      if (f) begin
        chk("stream_resp", 64'(resp_msg),
            64'(rs(3'd0, 8'(8'h40 + got), 2'd0, 2'd0, 32'hdeadbeef)));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (a && f) both++;
      if (a) idx++;
      if (cyc == 7) begin
        chk("stall_accepts", 64'(idx), 64'd4);
        chk("stall_rdy", 64'(req_rdy), 64'd0);
        chk("stall_val", 64'(resp_val), 64'd1);
      end
      step();
    end
    req_val = 1'b0;
    chk("stream_got", 64'(got), 64'd10);
    chk("stream_acc", 64'(idx), 64'd10);
    chk("stream_rate", 64'(last - first), 64'd9);
    chk("acc_fire_same", 64'(both != 0), 64'd1);

    // reset with responses outstanding
    resp_rdy = 1'b0;
    issue(rq(3'd0, 8'h50, 32'h10, 2'd0, 32'h0));
    issue(rq(3'd0, 8'h51, 32'h10, 2'd0, 32'h0));
    issue(rq(3'd0, 8'h52, 32'h10, 2'd0, 32'h0));
    repeat (3) step();
    chk("t5_pending", 64'(resp_val), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_val", 64'(resp_val), 64'd0);
    chk("t5_rst_rdy", 64'(req_rdy), 64'd0);
    chk("t5_rst_msg", 64'(resp_msg), 64'd0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("t5_rel_rdy", 64'(req_rdy), 64'd1);
    resp_rdy = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (resp_val) seen++;
    end
    chk("t5_no_stale", 64'(seen), 64'd0);
    txn("t5_after", rq(3'd0, 8'h55, 32'h10, 2'd0, 32'h0),
        rs(3'd0, 8'h55, 2'd0, 2'd0, 32'hdeadbeef));

    // out-of-range address
    txn("t6_w0", rq(3'd1, 8'h60, 32'h0, 2'd0, 32'hcafef00d),
        rs(3'd1, 8'h60, 2'd0, 2'd0, 32'h0));
`ifdef LAB2_MEM_RESP_ADDR_CHECK_EN
    txn("t6_w_oob", rq(3'd1, 8'h61, 32'h400, 2'd0, 32'h12345678),
        rs(3'd1, 8'h61, 2'b01, 2'd0, 32'h0));
    txn("t6_r_oob", rq(3'd0, 8'h62, 32'h400, 2'd0, 32'h0),
        rs(3'd0, 8'h62, 2'b01, 2'd0, 32'h0));
    txn("t6_r0", rq(3'd0, 8'h63, 32'h0, 2'd0, 32'h0),
        rs(3'd0, 8'h63, 2'd0, 2'd0, 32'hcafef00d));
`else
    txn("t6_r_wrap", rq(3'd0, 8'h62, 32'h400, 2'd0, 32'h0),
        rs(3'd0, 8'h62, 2'd0, 2'd0, 32'hcafef00d));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
